// File: rtl/dc_tag_rmw_ctrl.sv
// Tag-bank read-modify-write controller: one core op in flight, read/compare/update/write-back, then ack.
// Ack 3 cycles after accept (4 with write-back); every handshake holds its payload while retry is high.
module dc_tag_rmw_ctrl #(
  parameter int Width   = 24,
  parameter int Size    = 32,
  parameter int ReqBits = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     core_req_valid,
  output logic                     core_req_retry,
  input  logic [ReqBits-1:0]       core_req_type,
  input  logic [$clog2(Size)-1:0]  core_req_pos,
  input  logic [17:0]              core_req_tag,
  output logic                     core_ack_valid,
  input  logic                     core_ack_retry,
  output logic                     core_ack_hit,
  output logic [2:0]               core_ack_state,
  output logic                     tb_req_valid,
  input  logic                     tb_req_retry,
  output logic                     tb_write,
  output logic [$clog2(Size)-1:0]  tb_req_pos,
  output logic [Width-1:0]         tb_req_data,
  input  logic                     tb_ack_valid,
  output logic                     tb_ack_retry,
  input  logic [Width-1:0]         tb_ack_data
);

  // Coherence encodings: I=0 S=1 E=2 M=3 US=4 UM=5; only those that transition are named.
  localparam logic [2:0] ST_I  = 3'd0;
  localparam logic [2:0] ST_S  = 3'd1;
  localparam logic [2:0] ST_US = 3'd4;
  localparam logic [2:0] ST_UM = 3'd5;

  // Load ops (and any unlisted type) leave the state alone, so only the memory ops are decoded.
  localparam logic [ReqBits-1:0] CORE_MOP_BEGIN   = ReqBits'(16);
  localparam logic [ReqBits-1:0] CORE_MOP_COMMIT  = ReqBits'(17);
  localparam logic [ReqBits-1:0] CORE_MOP_CSYNC   = ReqBits'(18);
  localparam logic [ReqBits-1:0] CORE_MOP_KILL    = ReqBits'(19);
  localparam logic [ReqBits-1:0] CORE_MOP_RESTART = ReqBits'(20);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, RESP} fsm_t;

  fsm_t                    state_q, state_d;
  logic [ReqBits-1:0]      type_q;
  logic [$clog2(Size)-1:0] pos_q;
  logic [17:0]             tag_q;
  logic                    hit_q;
  logic [2:0]              st_q;
  logic [Width-1:0]        wr_q;

  logic [17:0]      ent_tag;
  logic             ent_rsv;
  logic [1:0]       ent_cnt;
  logic [2:0]       ent_st;
  logic             lookup_hit;
  logic             need_wr;
  logic [2:0]       new_st;
  logic [1:0]       new_cnt;
  logic [Width-1:0] new_entry;

  assign ent_tag = tb_ack_data[17:0];
  assign ent_rsv = tb_ack_data[18];
  assign ent_cnt = tb_ack_data[20:19];
  assign ent_st  = tb_ack_data[23:21];

  always_comb begin
    new_st  = ent_st;
    new_cnt = (ent_cnt == 2'd3) ? 2'd3 : ent_cnt + 2'd1;
    case (type_q)
      CORE_MOP_BEGIN:                  if (ent_st == ST_UM) new_st = ST_US;
      CORE_MOP_COMMIT, CORE_MOP_CSYNC: if (ent_st == ST_US) new_st = ST_S;
      CORE_MOP_KILL, CORE_MOP_RESTART: begin
        new_st  = ST_I;
        new_cnt = 2'd0;
      end
      default: ;
    endcase
    new_entry        = '0;
    new_entry[17:0]  = ent_tag;
    new_entry[18]    = ent_rsv;
    new_entry[20:19] = new_cnt;
    new_entry[23:21] = new_st;
  end

  assign lookup_hit = (ent_tag == tag_q) && (ent_st != ST_I);
  assign need_wr    = lookup_hit && ((new_st != ent_st) || (new_cnt != ent_cnt));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (core_req_valid)  state_d = RD_REQ;
      RD_REQ:  if (!tb_req_retry)   state_d = RD_WAIT;
      RD_WAIT: if (tb_ack_valid)    state_d = need_wr ? WR_REQ : RESP;
      WR_REQ:  if (!tb_req_retry)   state_d = RESP;
      RESP:    if (!core_ack_retry) state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      type_q <= '0;
      pos_q  <= '0;
      tag_q  <= '0;
      hit_q  <= 1'b0;
      st_q   <= ST_I;
      wr_q   <= '0;
    end else begin
      if (state_q == IDLE && core_req_valid) begin
        type_q <= core_req_type;
        pos_q  <= core_req_pos;
        tag_q  <= core_req_tag;
      end
      if (state_q == RD_WAIT && tb_ack_valid) begin
        hit_q <= lookup_hit;
        st_q  <= lookup_hit ? new_st : ST_I;
        wr_q  <= new_entry;
      end
    end
  end

  // Outputs decode from the state register so nothing passes combinationally from the core side.
  assign core_req_retry = (state_q != IDLE);
  assign tb_req_valid   = (state_q == RD_REQ) || (state_q == WR_REQ);
  assign tb_write       = (state_q == WR_REQ);
  assign tb_req_pos     = tb_req_valid ? pos_q : '0;
  assign tb_req_data    = (state_q == WR_REQ) ? wr_q : '0;
  assign tb_ack_retry   = 1'b0;
  assign core_ack_valid = (state_q == RESP);
  assign core_ack_hit   = (state_q == RESP) && hit_q;
  assign core_ack_state = (state_q == RESP) ? st_q : ST_I;

endmodule

// File: tb/tb_dc_tag_rmw_ctrl.sv
// Directed bench for dc_tag_rmw_ctrl with a small tag-bank responder and hand-computed results.
module tb_dc_tag_rmw_ctrl;

  localparam logic [4:0] L8U = 5'h00, L32S = 5'h05, L64U = 5'h06;
  localparam logic [4:0] BEGIN = 5'h10, COMMIT = 5'h11, CSYNC = 5'h12, KILL = 5'h13, RESTART = 5'h14;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_req_valid;
  logic        core_req_retry;
  logic [4:0]  core_req_type;
  logic [4:0]  core_req_pos;
  logic [17:0] core_req_tag;
  logic        core_ack_valid;
  logic        core_ack_retry;
  logic        core_ack_hit;
  logic [2:0]  core_ack_state;
  logic        tb_req_valid;
  logic        tb_req_retry;
  logic        tb_write;
  logic [4:0]  tb_req_pos;
  logic [23:0] tb_req_data;
  logic        tb_ack_valid;
  logic        tb_ack_retry;
  logic [23:0] tb_ack_data;

  dc_tag_rmw_ctrl #(.Width(24), .Size(32), .ReqBits(5)) dut (
    .clk(clk), .reset(reset),
    .core_req_valid(core_req_valid), .core_req_retry(core_req_retry),
    .core_req_type(core_req_type), .core_req_pos(core_req_pos), .core_req_tag(core_req_tag),
    .core_ack_valid(core_ack_valid), .core_ack_retry(core_ack_retry),
    .core_ack_hit(core_ack_hit), .core_ack_state(core_ack_state),
    .tb_req_valid(tb_req_valid), .tb_req_retry(tb_req_retry), .tb_write(tb_write),
    .tb_req_pos(tb_req_pos), .tb_req_data(tb_req_data),
    .tb_ack_valid(tb_ack_valid), .tb_ack_retry(tb_ack_retry), .tb_ack_data(tb_ack_data)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errs    = 0;

  logic [23:0] mem [32];
  int          n_rd, n_wr, n_ack, ack_cyc, stable_err, retry_err, quiet_err;
  logic [23:0] wdat;
  logic        ack_hit;
  logic [2:0]  ack_st;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one op starting at cycle 0 (caller sits #1 after an edge) and plays the bank with stalls.
  task automatic run_op(input logic [4:0] typ, input logic [4:0] pos, input logic [17:0] tag,
                        input int rd_stall, input int wr_stall, input int ack_stall);
    int          rd_c, wr_c, ack_c;
    logic        ack_pend, done;
    logic [4:0]  rd_pos, pos_seen;
    logic [23:0] dat_seen;
    logic [3:0]  resp_seen;
    rd_c = 0; wr_c = 0; ack_c = 0; ack_pend = 1'b0; done = 1'b0;
    rd_pos = '0; pos_seen = '0; dat_seen = '0; resp_seen = '0;
    n_rd = 0; n_wr = 0; n_ack = 0; ack_cyc = -1; stable_err = 0; retry_err = 0;
    wdat = '0; ack_hit = 1'bx; ack_st = 3'bx;
    chk("idle_req_retry", {31'd0, core_req_retry}, 32'd0);
    core_req_valid = 1'b1; core_req_type = typ; core_req_pos = pos; core_req_tag = tag;
    tick();
    core_req_valid = 1'b0; core_req_type = '0; core_req_pos = '0; core_req_tag = '0;
    for (int cyc = 1; cyc < 100 && !done; cyc++) begin
      tb_req_retry = 1'b0; core_ack_retry = 1'b0; tb_ack_valid = 1'b0; tb_ack_data = '0;
      if (ack_pend) begin
        tb_ack_valid = 1'b1;
        tb_ack_data  = mem[rd_pos];
        ack_pend     = 1'b0;
      end
      if (core_req_retry !== 1'b1) retry_err++;
      if (tb_req_valid === 1'b1 && tb_write === 1'b0) begin
        if (rd_c > 0 && tb_req_pos !== pos_seen) stable_err++;
        pos_seen = tb_req_pos;
        if (rd_c < rd_stall) begin
          tb_req_retry = 1'b1; rd_c++;
        end else begin
          n_rd++; rd_pos = tb_req_pos; ack_pend = 1'b1;
        end
      end
      if (tb_req_valid === 1'b1 && tb_write === 1'b1) begin
        if (wr_c > 0 && (tb_req_pos !== pos_seen || tb_req_data !== dat_seen)) stable_err++;
        pos_seen = tb_req_pos; dat_seen = tb_req_data;
        if (wr_c < wr_stall) begin
          tb_req_retry = 1'b1; wr_c++;
        end else begin
          n_wr++; wdat = tb_req_data; mem[tb_req_pos] = tb_req_data;
        end
      end
      if (core_ack_valid === 1'b1) begin
        if (ack_c > 0 && {core_ack_hit, core_ack_state} !== resp_seen) stable_err++;
        resp_seen = {core_ack_hit, core_ack_state};
        if (ack_c < ack_stall) begin
          core_ack_retry = 1'b1; ack_c++;
        end else begin
          n_ack++; ack_cyc = cyc; ack_hit = core_ack_hit; ack_st = core_ack_state; done = 1'b1;
        end
      end
      tick();
    end
    tb_req_retry = 1'b0; core_ack_retry = 1'b0; tb_ack_valid = 1'b0; tb_ack_data = '0;
    chk("op_completed", {31'd0, done}, 32'd1);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk(tag, {core_req_retry, core_ack_valid, core_ack_hit, core_ack_state, tb_req_valid,
              tb_write, tb_req_pos, tb_ack_retry}, 32'd0);
    chk(tag, {8'd0, tb_req_data}, 32'd0);
  endtask

  initial begin
    #20000;
    $display("FAIL global_timeout: simulation did not end by itself");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; core_req_valid = 1'b0; core_req_type = '0; core_req_pos = '0; core_req_tag = '0;
    core_ack_retry = 1'b0; tb_req_retry = 1'b0; tb_ack_valid = 1'b0; tb_ack_data = '0;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    mem[3]  = {3'd1, 2'd3, 1'b0, 18'h01234};
    mem[5]  = {3'd2, 2'd0, 1'b1, 18'h3FFFF};
    mem[6]  = {3'd3, 2'd2, 1'b0, 18'h00001};
    mem[7]  = {3'd5, 2'd1, 1'b1, 18'h00ABC};
    mem[8]  = {3'd4, 2'd3, 1'b0, 18'h00055};
    mem[9]  = {3'd2, 2'd0, 1'b0, 18'h25A5A};
    mem[12] = {3'd3, 2'd2, 1'b0, 18'h11111};
    mem[20] = {3'd4, 2'd0, 1'b0, 18'h30F0F};
    tick(); tick();
    chk_outputs_zero("reset_outputs");
    reset = 1'b0;
    tick();

    // Load hit with saturated counter: nothing changes, minimum latency without write.
    run_op(L64U, 5'd3, 18'h01234, 0, 0, 0);
    chk("l64u_hit", {31'd0, ack_hit}, 32'd1);
    chk("l64u_state", {29'd0, ack_st}, 32'd1);
    chk("l64u_writes", n_wr, 0);
    chk("l64u_ack_cycle", ack_cyc, 3);

    // BEGIN on UM: state to US, counter 1->2, reserved bit preserved.
    run_op(BEGIN, 5'd7, 18'h00ABC, 0, 0, 0);
    chk("begin_wdata", {8'd0, wdat}, 32'h940ABC);
    chk("begin_hit", {31'd0, ack_hit}, 32'd1);
    chk("begin_state", {29'd0, ack_st}, 32'd4);
    chk("begin_ack_cycle", ack_cyc, 4);

    // Load hit on an unsaturated counter still writes back the bumped counter.
    run_op(L32S, 5'd5, 18'h3FFFF, 0, 0, 0);
    chk("l32s_wdata", {8'd0, wdat}, 32'h4FFFFF);
    chk("l32s_state", {29'd0, ack_st}, 32'd2);

    // KILL on E, then a load to the same tag now misses.
    run_op(KILL, 5'd9, 18'h25A5A, 0, 0, 0);
    chk("kill_wdata", {8'd0, wdat}, 32'h025A5A);
    chk("kill_hit", {31'd0, ack_hit}, 32'd1);
    chk("kill_state", {29'd0, ack_st}, 32'd0);
    run_op(L8U, 5'd9, 18'h25A5A, 0, 0, 0);
    chk("after_kill_hit", {31'd0, ack_hit}, 32'd0);
    chk("after_kill_state", {29'd0, ack_st}, 32'd0);
    chk("after_kill_writes", n_wr, 0);

    // RESTART on M clears state and counter; CSYNC on US goes to S with counter held at 3.
    run_op(RESTART, 5'd6, 18'h00001, 0, 0, 0);
    chk("restart_wdata", {8'd0, wdat}, 32'h000001);
    run_op(CSYNC, 5'd8, 18'h00055, 0, 0, 0);
    chk("csync_wdata", {8'd0, wdat}, 32'h380055);
    chk("csync_state", {29'd0, ack_st}, 32'd1);

    // Tag mismatch on a valid entry.
    run_op(L64U, 5'd12, 18'h22222, 0, 0, 0);
    chk("miss_hit", {31'd0, ack_hit}, 32'd0);
    chk("miss_state", {29'd0, ack_st}, 32'd0);
    chk("miss_writes", n_wr, 0);
    chk("miss_ack_cycle", ack_cyc, 3);

    // Backpressure on every handshake: read x3, write x2, ack x2.
    run_op(COMMIT, 5'd20, 18'h30F0F, 3, 2, 2);
    chk("bp_reads", n_rd, 1);
    chk("bp_writes", n_wr, 1);
    chk("bp_acks", n_ack, 1);
    chk("bp_stable", stable_err, 0);
    chk("bp_req_retry", retry_err, 0);
    chk("bp_wdata", {8'd0, wdat}, 32'h2B0F0F);
    chk("bp_ack_cycle", ack_cyc, 11);

    // Reset while waiting for the read data, then a stale ack arrives.
    core_req_valid = 1'b1; core_req_type = BEGIN; core_req_pos = 5'd7; core_req_tag = 18'h00ABC;
    tick();
    core_req_valid = 1'b0;
    chk("rst_mid_read_valid", {31'd0, tb_req_valid}, 32'd1);
    tick();
    reset = 1'b1;
    tick();
    chk_outputs_zero("rst_mid_outputs");
    reset = 1'b0;
    mem[7] = {3'd5, 2'd1, 1'b0, 18'h00ABC};
    tb_ack_valid = 1'b1; tb_ack_data = mem[7];
    quiet_err = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      tb_ack_valid = 1'b0; tb_ack_data = '0;
      if (tb_req_valid !== 1'b0 || core_ack_valid !== 1'b0 || core_req_retry !== 1'b0) quiet_err++;
    end
    chk("rst_stale_ack_ignored", quiet_err, 0);
    run_op(BEGIN, 5'd7, 18'h00ABC, 0, 0, 0);
    chk("rst_next_wdata", {8'd0, wdat}, 32'h900ABC);
    chk("rst_next_state", {29'd0, ack_st}, 32'd4);
    chk("rst_next_ack_cycle", ack_cyc, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/dc_tag_rmw_ctrl.md
# dc_tag_rmw_ctrl

Initiator-side controller for the L1 data-cache tag bank. It accepts one core tag operation at a time and reads the selected tag entry through the bank's valid/retry port. It compares the stored tag, computes the next coherence state and access counter, writes the entry back when it changed, and returns hit, miss and new state to the core pipeline. It sits between the DC request pipeline and one tag bank instance.

## Interface
- `Width`, 24: tag entry width. Fields are tag [17:0], reserved [18], counter [20:19] and state [23:21].
- `Size`, 32: number of entries (sets) in the bank. The position is `log2(Size)` bits wide.
- `ReqBits`, 5: width of the core op type field.
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high.
- `core_req_valid`, in, 1: core operation valid.
- `core_req_retry`, out, 1: core operation not accepted this cycle.
- `core_req_type`, in, `ReqBits`: op type (`CORE_LOP_*` / `CORE_MOP_*`).
- `core_req_pos`, in, `log2(Size)`: set index.
- `core_req_tag`, in, 18: lookup tag.
- `core_ack_valid`, out, 1: result valid.
- `core_ack_retry`, in, 1: core cannot take the result.
- `core_ack_hit`, out, 1: tag match with a non-I state.
- `core_ack_state`, out, 3: state after the operation (I on a miss).
- `tb_req_valid`, out, 1: bank request valid.
- `tb_req_retry`, in, 1: bank stall.
- `tb_write`, out, 1: 1 means write, 0 means read.
- `tb_req_pos`, out, `log2(Size)`: bank set index.
- `tb_req_data`, out, `Width`: write data (0 on reads).
- `tb_ack_valid`, in, 1: read data valid.
- `tb_ack_retry`, out, 1: driven constant 0.
- `tb_ack_data`, in, `Width`: read entry.

## Operation
- **Handshake rule.** A transfer occurs on any valid/retry pair when valid=1 and retry=0 in the same cycle. A valid signal, once raised, is held with stable payload until it transfers.
- **State encodings.** I=0, S=1, E=2, M=3, US=4, UM=5.
- **FSM states.** IDLE, RD_REQ, RD_WAIT, WR_REQ, RESP.
- **IDLE**
  - `core_req_retry`=0.
  - On a core transfer, latch type, pos and tag, then go to RD_REQ.
  - In every other state `core_req_retry`=1.
- **RD_REQ**
  - Drive `tb_req_valid`=1, `tb_write`=0, `tb_req_pos`=latched pos.
  - On transfer go to RD_WAIT. While `tb_req_retry`=1, stay.
- **RD_WAIT**
  - Wait for `tb_ack_valid`, then latch `tb_ack_data`.
  - hit = (entry tag == latched tag) and (state != I).
- **Next state on a hit**
  - Load ops (`CORE_LOP_L*`): state unchanged.
  - `CORE_MOP_BEGIN`: UM goes to US. All other states are unchanged.
  - `CORE_MOP_COMMIT` and `CORE_MOP_CSYNC`: US goes to S. All other states are unchanged.
  - `CORE_MOP_KILL` and `CORE_MOP_RESTART`: any state goes to I.
  - Any other type: state unchanged.
- **Counter on a hit.** counter+1, saturating at 3. On KILL/RESTART the counter is 0.
- **Write decision**
  - On a hit, write back only if the state or counter changed; otherwise go straight to RESP.
  - On a miss, never write. Result is hit=0, state=I.
- **WR_REQ**
  - Drive `tb_req_valid`=1 and `tb_write`=1.
  - `tb_req_data` = {new state, new counter, reserved bit as read, stored tag}.
  - On transfer go to RESP. While `tb_req_retry`=1, stay.
- **RESP**
  - Drive `core_ack_valid`=1 with hit and state.
  - On transfer go to IDLE.
- **Ignored acks.** `tb_ack_valid` is ignored outside RD_WAIT.

## Timing
- **Reset values.** FSM=IDLE. All outputs are 0: `core_req_retry`, `core_ack_*`, `tb_req_valid`, `tb_write`, `tb_req_pos`, `tb_req_data`, `tb_ack_retry`.
- **Reset mid-operation.** Any in-flight operation is abandoned with no write and no ack. A late `tb_ack_valid` after reset is ignored.
- **Minimum latency** (accept at cycle 0, no retries, bank ack the cycle after the read transfer):
  - Read issued at cycle 1.
  - Ack at cycle 2.
  - Write at cycle 3 if needed.
  - `core_ack_valid` at cycle 3 with no write, or cycle 4 with a write.
- **Throughput.** One operation in flight. The next core request is accepted in the cycle after the RESP transfer, because IDLE is re-entered on that edge.
- **Registered outputs.** All outputs are registered or decoded from FSM state only. There is no combinational path from `core_req_valid` to `tb_req_valid`.
- **Write/ack ordering.** The write-back completes before the core sees the ack, so a subsequent op to the same set observes the updated entry.

## Test plan
- **Load hit, counter saturates.** Entry at pos 3 = {state S, counter 3, tag 0x1234}; `CORE_LOP_L64U` with tag 0x1234 -> hit=1, state=1, no `tb_write`, ack at cycle 3.
- **BEGIN on UM.** Entry {UM, counter 1, tag 0x00ABC} at pos 7; `CORE_MOP_BEGIN` -> write data {4, 2, r, 0x00ABC}, hit=1, state=4, ack at cycle 4.
- **KILL, then load.** `CORE_MOP_KILL` hit on an E entry -> written {0, 0, tag}. A following load to the same tag -> hit=0, state=0.
- **Tag mismatch.** Stored tag 0x11111, request tag 0x22222 -> hit=0, state=0, no write.
- **Backpressure.** `tb_req_retry`=1 for 3 cycles on the read and 2 on the write, and `core_ack_retry`=1 for 2 cycles -> payloads stay stable, exactly one read, one write and one ack, and `core_req_retry`=1 throughout.
- **Reset mid-operation.** Reset asserted in RD_WAIT, then `tb_ack_valid` pulses -> no write, no `core_ack_valid`, all outputs 0; the next request completes normally.
